// File: rtl/page_sequencer.sv
// Page index owner: debounced prev/next buttons and a slideshow timer move a target that commits at a frame boundary.
// Latency: button event DEBOUNCE_CYCLES+3 clk after the raw edge; page_idx updates 2 clk after the synced vsync fall.
// Backpressure: none; events arriving while a target is pending accumulate into it, out-of-range events are dropped.
module page_sequencer #(
    parameter int PAGE_MAX        = 4,
    parameter int PAGE_W          = 10,
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int AUTO_PERIOD     = 300_000_000,
    parameter int WRAP            = 0
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              ena,
    input  logic              pgup,
    input  logic              pgdown,
    input  logic              auto_en,
    input  logic              vsync,
    output logic [PAGE_W-1:0] page_idx,
    output logic [26:0]       page_num,
    output logic              pending,
    output logic              at_first,
    output logic              at_last
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int AT_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AT_W-1:0]   AT_LAST = AT_W'(AUTO_PERIOD - 1);
    localparam logic [PAGE_W-1:0] P_MAX   = PAGE_W'(PAGE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_COMMIT} state_t;

    // bit 0 pgup, bit 1 pgdown, bit 2 auto_en, bit 3 vsync
    logic [3:0]             r_sync1;
    logic [3:0]             r_sync2;
    logic                   r_vs_d;
    logic [1:0][DB_W-1:0]   r_db_cnt;
    logic [1:0]             r_db_lvl;
    logic [1:0]             r_db_lvl_d;
    logic [AT_W-1:0]        r_auto_cnt;
    state_t                 r_state;
    logic [PAGE_W-1:0]      r_target;
    logic [PAGE_W-1:0]      r_page_idx;
    logic [26:0]            r_page_num;
    logic                   r_at_first;
    logic                   r_at_last;

    logic                   w_frame;
    logic [1:0]             w_press;
    logic                   w_up_man;
    logic                   w_dn_man;
    logic                   w_auto_stop;
    logic                   w_auto_run;
    logic                   w_auto_evt;
    logic                   w_dn;
    logic [PAGE_W-1:0]      w_base;
    logic [PAGE_W-1:0]      w_new;
    logic                   w_acc;
    logic                   w_man_acc;
    state_t                 w_state_nxt;
    logic [PAGE_W-1:0]      w_target_nxt;
    logic                   w_commit;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_vs_d  <= 1'b0;
        end else begin
            r_sync1 <= {vsync, auto_en, pgdown, pgup};
            r_sync2 <= r_sync1;
            r_vs_d  <= r_sync2[3];
        end
    end

    assign w_frame = r_vs_d & ~r_sync2[3];

    // Debouncers run regardless of ena so a button held across ena rising is already settled.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_db_cnt   <= '0;
            r_db_lvl   <= '0;
            r_db_lvl_d <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_db_lvl[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db_cnt[i] <= '0;
                    r_db_lvl[i] <= r_sync2[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
            r_db_lvl_d <= r_db_lvl;
        end
    end

    assign w_press     = r_db_lvl & ~r_db_lvl_d;
    assign w_up_man    = w_press[0] & ena;
    assign w_dn_man    = w_press[1] & ena;
    assign w_auto_stop = (WRAP == 0) && (r_page_idx == P_MAX);
    assign w_auto_run  = r_sync2[2] && ena && (r_state == S_IDLE) && !w_auto_stop;
    assign w_auto_evt  = w_auto_run && (r_auto_cnt == AT_LAST);
    assign w_dn        = w_dn_man | w_auto_evt;
    assign w_base      = (r_state != S_IDLE) ? r_target : r_page_idx;

    always_comb begin
        w_acc = 1'b0;
        w_new = w_base;
        if (w_up_man && !w_dn) begin
            if (w_base == '0) begin
                if (WRAP != 0) begin
                    w_acc = 1'b1;
                    w_new = P_MAX;
                end
            end else begin
                w_acc = 1'b1;
                w_new = w_base - 1'b1;
            end
        end else if (w_dn && !w_up_man) begin
            if (w_base == P_MAX) begin
                if (WRAP != 0) begin
                    w_acc = 1'b1;
                    w_new = '0;
                end
            end else begin
                w_acc = 1'b1;
                w_new = w_base + 1'b1;
            end
        end
    end

    assign w_man_acc = w_acc && (w_up_man || w_dn_man);

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_auto_cnt <= '0;
        end else if (!r_sync2[2] || !ena || w_man_acc) begin
            r_auto_cnt <= '0;
        end else if (w_auto_run) begin
            r_auto_cnt <= (r_auto_cnt == AT_LAST) ? '0 : r_auto_cnt + 1'b1;
        end else if (w_auto_stop) begin
            r_auto_cnt <= '0;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_commit     = 1'b0;
        if (!ena) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        w_target_nxt = w_new;
                        w_state_nxt  = S_PEND;
                    end
                end
                S_PEND: begin
                    if (w_acc) w_target_nxt = w_new;
                    if (w_frame) w_state_nxt = S_COMMIT;
                end
                S_COMMIT: begin
                    w_commit = 1'b1;
                    if (w_acc) begin
                        w_target_nxt = w_new;
                        w_state_nxt  = S_PEND;
                    end else begin
                        w_state_nxt  = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_target   <= '0;
            r_page_idx <= '0;
            r_page_num <= 27'd1;
            r_at_first <= 1'b1;
            r_at_last  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
            if (w_commit) begin
                r_page_idx <= r_target;
                r_page_num <= 27'(r_target) + 27'd1;
            end
            r_at_first <= (r_page_idx == '0);
            r_at_last  <= (r_page_idx == P_MAX);
        end
    end

    assign page_idx = r_page_idx;
    assign page_num = r_page_num;
    assign pending  = (r_state != S_IDLE);
    assign at_first = r_at_first;
    assign at_last  = r_at_last;

endmodule
